driver_sout_reader: RTL and testbench
=====================================

Name: driver_sout_reader

Overview:
- Receive-side companion to driver_controller: deserializes the SOUT shift-out of one selected LED driver while the controller clocks it with driver_sclk.
- Selects the driver through the SOUT mux, captures one WORD_WIDTH-bit word MSB first, and compares it against the configuration that was sent.
- Used for configuration readback and link checking of the driver chain; runs in the main 33 MHz clk domain.

Parameters:
NB_DRIVERS, 30, number of selectable drivers on the SOUT mux
WORD_WIDTH, 48, bits per readback word (matches serialized_conf width)
SETTLE_CYCLES, 4, clk cycles waited after a mux change before sampling
TIMEOUT, 4096, clk cycles allowed without an sclk rising edge before aborting

Ports:
clk  in  1  main clock
nrst  in  1  asynchronous active-low reset
driver_sclk  in  1  registered sclk as driven by driver_controller
driver_lat  in  1  registered latch as driven by driver_controller
driver_sout  in  1  muxed SOUT pin from drivers (asynchronous to clk)
driver_sout_mux  out  5  selected driver index
start  in  1  one-cycle request to begin a readback
driver_idx  in  5  driver to read, sampled with start
expected_conf  in  WORD_WIDTH  reference word, sampled with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
readback_valid  out  1  high with done when a full word was captured
readback_data  out  WORD_WIDTH  captured word, held until next capture
conf_match  out  1  readback_data == sampled expected_conf, valid with readback_valid
timeout_err  out  1  high with done when the capture timed out

Behaviour:
- Reset (async, nrst low): state IDLE; driver_sout_mux=0; busy, done, readback_valid, conf_match, timeout_err = 0; readback_data = 0; all counters = 0.
- driver_sout passes through a 2-flop synchronizer. driver_sclk and driver_lat are delayed by 2 flops to keep alignment. An sclk rise is delayed sclk high while its previous delayed value was low. A lat rise is detected the same way.
- IDLE: start=1 with driver_idx < NB_DRIVERS is accepted. It latches driver_idx into driver_sout_mux, latches expected_conf, sets busy=1 and enters SETTLE on the next cycle. start with driver_idx >= NB_DRIVERS is ignored (no busy, no done).
- start while busy is ignored.
- SETTLE: counts SETTLE_CYCLES clk cycles, then enters SHIFT with bit counter=0 and timeout counter=0. sclk rises during SETTLE are not sampled.
- SHIFT: on each sclk rise, shift = {shift[WORD_WIDTH-2:0], synced sout}, bit counter +1, timeout counter cleared. Otherwise the timeout counter increments.
  - Bit counter reaching WORD_WIDTH enters DONE.
  - Timeout counter reaching TIMEOUT-1 enters DONE with the error flag set.
- lat rise in SHIFT: bit counter and shift are cleared and capture restarts. If an sclk rise occurs in the same cycle, the restart wins and that bit is discarded.
- DONE (single cycle): done=1 and busy drops to 0 the same cycle. Returns to IDLE next cycle.
  - Success: readback_valid=1, readback_data=shift, conf_match=(shift==latched expected_conf), timeout_err=0.
  - Timeout: readback_valid=0, timeout_err=1, readback_data and conf_match unchanged.
- done, readback_valid and timeout_err are one-cycle pulses. conf_match and readback_data hold until the next successful capture.
- driver_sout_mux holds its value after DONE until the next accepted start.
- Latency: done asserts 1 clk after the WORD_WIDTH-th detected sclk rise, which is 3 clk after the raw sclk rise including the delay stages.
- Bit counter is 6 bits. Timeout counter is clog2(TIMEOUT) bits and never wraps: it saturates into DONE.
- nrst asserted mid-capture returns everything to reset values immediately. No done is issued.

Test Plan:
- Reset: drive nrst low mid-SHIFT -> all outputs 0, mux=0 asynchronously; after release, busy=0.
- Nominal: start, idx=7, expected=48'hA5A5_0F0F_1234; after settle, drive 48 sclk pulses (period 4 clk) with sout MSB first = expected -> mux=7, done+readback_valid+conf_match=1, readback_data=48'hA5A5_0F0F_1234.
- Mismatch: same as nominal but flip bit 0 -> readback_valid=1, conf_match=0, readback_data=48'hA5A5_0F0F_1235.
- Timeout: start, then no sclk -> done and timeout_err pulse exactly TIMEOUT cycles after SETTLE ends; readback_valid=0, previous readback_data retained.
- Lat restart: 20 bits of garbage, lat pulse, then 48 bits of 48'h0000_FFFF_0000 -> readback_data=48'h0000_FFFF_0000, conf_match=1 when that value is expected.
- Guarding: start with idx=31 -> no busy. Second start while busy with idx=2 -> ignored, mux stays at the first index.

Source files
------------

// File: rtl/driver_sout_reader.sv
// SOUT readback deserializer for the LED driver chain.
// Captures one word from the selected driver and compares it to the sent config.
module driver_sout_reader #(
  parameter int NB_DRIVERS    = 30,
  parameter int WORD_WIDTH    = 48,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  driver_sclk,
  input  logic                  driver_lat,
  input  logic                  driver_sout,
  output logic [4:0]            driver_sout_mux,
  input  logic                  start,
  input  logic [4:0]            driver_idx,
  input  logic [WORD_WIDTH-1:0] expected_conf,
  output logic                  busy,
  output logic                  done,
  output logic                  readback_valid,
  output logic [WORD_WIDTH-1:0] readback_data,
  output logic                  conf_match,
  output logic                  timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SET_MAX  = SW'(SETTLE_CYCLES - 1);
  localparam logic [5:0]    LAST_BIT = 6'(WORD_WIDTH - 1);
  localparam logic [5:0]    NB       = 6'(NB_DRIVERS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]            state;
  logic                  sout_s1, sout_s2;
  logic                  sclk_d1, sclk_d2, sclk_d3;
  logic                  lat_d1, lat_d2, lat_d3;
  logic [WORD_WIDTH-1:0] shift;
  logic [WORD_WIDTH-1:0] exp_q;
  logic [5:0]            bit_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [SW-1:0]         set_cnt;

  logic                  sclk_rise;
  logic                  lat_rise;
  logic                  idx_ok;
  logic [WORD_WIDTH-1:0] shift_nxt;

  assign sclk_rise = sclk_d2 & ~sclk_d3;
  assign lat_rise  = lat_d2 & ~lat_d3;
  assign idx_ok    = {1'b0, driver_idx} < NB;
  assign shift_nxt = {shift[WORD_WIDTH-2:0], sout_s2};

  // sclk/lat go through the same two stages as sout so edges stay aligned
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sout_s1 <= 1'b0;
      sout_s2 <= 1'b0;
      sclk_d1 <= 1'b0;
      sclk_d2 <= 1'b0;
      sclk_d3 <= 1'b0;
      lat_d1  <= 1'b0;
      lat_d2  <= 1'b0;
      lat_d3  <= 1'b0;
    end else begin
      sout_s1 <= driver_sout;
      sout_s2 <= sout_s1;
      sclk_d1 <= driver_sclk;
      sclk_d2 <= sclk_d1;
      sclk_d3 <= sclk_d2;
      lat_d1  <= driver_lat;
      lat_d2  <= lat_d1;
      lat_d3  <= lat_d2;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      driver_sout_mux <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      readback_valid  <= 1'b0;
      readback_data   <= '0;
      conf_match      <= 1'b0;
      timeout_err     <= 1'b0;
      shift           <= '0;
      exp_q           <= '0;
      bit_cnt         <= '0;
      tmo_cnt         <= '0;
      set_cnt         <= '0;
    end else begin
      done           <= 1'b0;
      readback_valid <= 1'b0;
      timeout_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && idx_ok) begin
            driver_sout_mux <= driver_idx;
            exp_q           <= expected_conf;
            busy            <= 1'b1;
            set_cnt         <= '0;
            state           <= SETTLE;
          end
        end
        SETTLE: begin
          if (set_cnt == SET_MAX) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
            shift   <= '0;
            state   <= SHIFT;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        SHIFT: begin
          // a latch pulse restarts the word and drops any coincident bit
          if (lat_rise) begin
            bit_cnt <= '0;
            shift   <= '0;
            tmo_cnt <= '0;
          end else if (sclk_rise) begin
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            tmo_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state          <= DONE;
              busy           <= 1'b0;
              done           <= 1'b1;
              readback_valid <= 1'b1;
              readback_data  <= shift_nxt;
              conf_match     <= (shift_nxt == exp_q);
            end
          end else if (tmo_cnt == TMO_MAX) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_driver_sout_reader.sv
// Directed bench for driver_sout_reader: table of readback words
// plus timeout, latch restart, guarding and reset sequences.
module tb_driver_sout_reader;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        sclk = 1'b0;
  logic        lat = 1'b0;
  logic        sout = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  idx = '0;
  logic [47:0] exp_conf = '0;
  logic [4:0]  mux;
  logic        busy, done, valid, match, tmo_err;
  logic [47:0] data;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [47:0] expv;
    logic [47:0] sent;
    logic        match;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  driver_sout_reader dut (
    .clk(clk),
    .nrst(nrst),
    .driver_sclk(sclk),
    .driver_lat(lat),
    .driver_sout(sout),
    .driver_sout_mux(mux),
    .start(start),
    .driver_idx(idx),
    .expected_conf(exp_conf),
    .busy(busy),
    .done(done),
    .readback_valid(valid),
    .readback_data(data),
    .conf_match(match),
    .timeout_err(tmo_err)
  );

  task automatic chk(input string name, input logic [47:0] act,
                     input logic [47:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic do_start(input logic [4:0] i, input logic [47:0] c);
    @(negedge clk);
    idx = i;
    exp_conf = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // one bit per 4 clk: sout set, sclk high 2 clk, low 2 clk
  task automatic send_bits(input logic [47:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sout = w[n-1-i];
      @(negedge clk);
      sclk = 1'b1;
      @(negedge clk);
      @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic wait_settle();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic seen;

    vecs[0] = '{5'd7,  48'hA5A5_0F0F_1234, 48'hA5A5_0F0F_1234, 1'b1};
    vecs[1] = '{5'd7,  48'hA5A5_0F0F_1234, 48'hA5A5_0F0F_1235, 1'b0};
    vecs[2] = '{5'd0,  48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b1};
    vecs[3] = '{5'd12, 48'h0000_0000_0000, 48'h0000_0000_0001, 1'b0};
    vecs[4] = '{5'd29, 48'h8000_0000_0001, 48'h8000_0000_0001, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_done", 48'(done), 48'd0);
    chk("rst_mux", 48'(mux), 48'd0);
    chk("rst_data", data, 48'd0);
    chk("rst_match", 48'(match), 48'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].idx, vecs[v].expv);
      chk("vec_busy", 48'(busy), 48'd1);
      chk("vec_mux", 48'(mux), 48'(vecs[v].idx));
      wait_settle();
      send_bits(vecs[v].sent, 48);
      chk("vec_done_early", 48'(done), 48'd0);
      @(negedge clk);
      chk("vec_done", 48'(done), 48'd1);
      chk("vec_valid", 48'(valid), 48'd1);
      chk("vec_match", 48'(match), 48'(vecs[v].match));
      chk("vec_data", data, vecs[v].sent);
      chk("vec_tmo", 48'(tmo_err), 48'd0);
      chk("vec_busy_off", 48'(busy), 48'd0);
      @(negedge clk);
      chk("vec_done_pulse", 48'(done), 48'd0);
      chk("vec_valid_pulse", 48'(valid), 48'd0);
      chk("vec_data_hold", data, vecs[v].sent);
      chk("vec_mux_hold", 48'(mux), 48'(vecs[v].idx));
    end

    // timeout: 4 settle + 4096 idle shift cycles
    do_start(5'd4, 48'h1111_2222_3333);
    cnt = 0;
    while (!done && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    chk("tmo_latency", 48'(cnt), 48'd4100);
    chk("tmo_err", 48'(tmo_err), 48'd1);
    chk("tmo_valid", 48'(valid), 48'd0);
    chk("tmo_data_kept", data, 48'h8000_0000_0001);
    chk("tmo_match_kept", 48'(match), 48'd1);
    chk("tmo_busy", 48'(busy), 48'd0);
    @(negedge clk);
    chk("tmo_err_pulse", 48'(tmo_err), 48'd0);

    // latch restart after garbage
    do_start(5'd3, 48'h0000_FFFF_0000);
    wait_settle();
    send_bits(48'h0000_000A_BCDE, 20);
    @(negedge clk);
    lat = 1'b1;
    @(negedge clk);
    @(negedge clk);
    lat = 1'b0;
    send_bits(48'h0000_FFFF_0000, 48);
    @(negedge clk);
    chk("lat_done", 48'(done), 48'd1);
    chk("lat_valid", 48'(valid), 48'd1);
    chk("lat_data", data, 48'h0000_FFFF_0000);
    chk("lat_match", 48'(match), 48'd1);

    // out-of-range indices are ignored
    do_start(5'd31, 48'h0);
    chk("idx31_busy", 48'(busy), 48'd0);
    do_start(5'd30, 48'h0);
    chk("idx30_busy", 48'(busy), 48'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("idx_bad_quiet", 48'(seen), 48'd0);
    chk("idx_bad_mux", 48'(mux), 48'd3);

    // start while busy is ignored
    do_start(5'd5, 48'h0);
    chk("busy_first", 48'(busy), 48'd1);
    do_start(5'd2, 48'h0);
    chk("busy_mux", 48'(mux), 48'd5);
    chk("busy_still", 48'(busy), 48'd1);

    // reset mid-capture
    wait_settle();
    send_bits(48'h0000_0000_02AA, 10);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mid_rst_busy", 48'(busy), 48'd0);
    chk("mid_rst_mux", 48'(mux), 48'd0);
    chk("mid_rst_data", data, 48'd0);
    chk("mid_rst_match", 48'(match), 48'd0);
    chk("mid_rst_done", 48'(done), 48'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 48'(busy), 48'd0);
    chk("post_rst_done", 48'(done), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
